conv_encoder: RTL

Rate-1/2, constraint-length-3 convolutional encoder (generators g0 = 7 octal, g1 = 5 octal) that produces the symbol pairs the Viterbi decoder's branch-metric stage consumes. It accepts a bit stream framed by `in_last` and emits one 2-bit code pair per accepted bit. It then appends K-1 = 2 zero tail bits so every frame ends in state 00, which is the decoder's traceback start state. Both sides use valid/ready handshakes, and the output is fully registered.

---
 rtl/conv_encoder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/conv_encoder.sv
// ---------------------------------------------------------------------------
// conv_encoder
//
// Rate-1/2, constraint-length-3 convolutional encoder with generators
// g0 = 7 (octal) and g1 = 5 (octal). Each accepted data bit produces one
// 2-bit code pair. After the bit flagged with in_last, two zero tail bits
// are encoded so that every frame leaves the encoder in state 00. That is
// the state the Viterbi traceback starts from.
//
// The output is a single fully registered slot. It refills on the same cycle
// it drains, which sustains one pair per clock.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : in_bit / in_last are valid
//   in_bit     : data bit to encode
//   in_last    : final data bit of the frame
//   in_ready   : encoder accepts a bit this cycle (combinational)
//   out_valid  : out_pair / out_last are valid
//   out_pair   : [1] = d^s1^s2 (g0), [0] = d^s2 (g1)
//   out_last   : final tail pair of the frame
//   out_ready  : downstream accepts out_pair
//   busy       : encoder is emitting the tail (registered)
//   frame_cnt  : frames whose last pair was accepted, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module conv_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [1:0]       out_pair,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        ST_DATA  = 2'd0,
        ST_TAIL1 = 2'd1,
        ST_TAIL2 = 2'd2
    } state_e;

    // Control state and encoder shift register (s1 = previous bit,
    // s2 = the bit before that).
    state_e state_q, state_d;
    logic   s1_q, s1_d;
    logic   s2_q, s2_d;

    // Output slot.
    logic       out_valid_q, out_valid_d;
    logic [1:0] out_pair_q,  out_pair_d;
    logic       out_last_q,  out_last_d;

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // Per-cycle decisions made by the FSM.
    logic slot_free;
    logic load;       // a new pair enters the output slot this cycle
    logic enc_bit;    // bit fed to the encoder (data bit or tail zero)
    logic load_last;  // the pair being loaded closes the frame
    logic last_xfer;  // the closing pair is handed downstream this cycle

    // The slot can take a new pair when it is empty or is draining this
    // cycle. Using out_ready here is what allows back-to-back pairs.
    assign slot_free = !out_valid_q || out_ready;
    assign last_xfer = out_valid_q && out_ready && out_last_q;

    // -----------------------------------------------------------------------
    // Next-state and handshake logic
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case
    // statement. A path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        load      = 1'b0;
        enc_bit   = 1'b0;
        load_last = 1'b0;

        unique case (state_q)
            ST_DATA: begin
                in_ready = slot_free;
                if (in_valid && slot_free) begin
                    load    = 1'b1;
                    enc_bit = in_bit;
                    if (in_last) begin
                        state_d = ST_TAIL1;
                    end
                end
            end

            ST_TAIL1: begin
                // First flush bit. Input stays blocked, even during a stall.
                if (slot_free) begin
                    load    = 1'b1;
                    state_d = ST_TAIL2;
                end
            end

            ST_TAIL2: begin
                // Second flush bit. After it the shift register is back to 00.
                if (slot_free) begin
                    load      = 1'b1;
                    load_last = 1'b1;
                    state_d   = ST_DATA;
                end
            end

            default: begin
                state_d = ST_DATA;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Encoder datapath and output slot
    // -----------------------------------------------------------------------
    always_comb begin
        s1_d        = s1_q;
        s2_d        = s2_q;
        out_pair_d  = out_pair_q;
        out_last_d  = out_last_q;
        // The slot stays occupied only while it is stalled. It is refilled
        // below if a pair is generated this cycle.
        out_valid_d = out_valid_q && !out_ready;

        if (load) begin
            out_valid_d = 1'b1;
            out_pair_d  = {enc_bit ^ s1_q ^ s2_q, enc_bit ^ s2_q};
            out_last_d  = load_last;
            s2_d        = s1_q;
            s1_d        = enc_bit;
        end
    end

    // busy tracks the state being entered, so the registered copy always
    // equals (state_q != ST_DATA).
    assign busy_d = (state_d != ST_DATA);

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (last_xfer) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Registers. A reset discards any pending pair and the partial frame.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples its pre-edge value, whatever order the
    // statements are written in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_DATA;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_pair_q  <= 2'b00;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_valid_q <= out_valid_d;
            out_pair_q  <= out_pair_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pair  = out_pair_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule
